// File: rtl/dpg_pkg.sv
// Shared types and helpers for the dual-phase square-wave generator.
package dpg_pkg;
  localparam int CNT_W_DEF = 32;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] phase;
  } cfg_t;

  localparam cfg_t CFG_RST = '{period: CNT_W_DEF'(2), high: CNT_W_DEF'(1), phase: '0};

  function automatic logic cfg_valid(input cfg_t c);
    return (c.period >= CNT_W_DEF'(2)) && (c.high != '0) &&
           (c.high < c.period) && (c.phase < c.period);
  endfunction

  // cntB value that pairs with cntA==0, i.e. (0-D) mod P
  function automatic logic [CNT_W_DEF-1:0] phase_start(input cfg_t c);
    return (c.phase == '0) ? '0 : c.period - c.phase;
  endfunction
endpackage

// File: rtl/dpg_wrap_counter.sv
// Loadable modulo counter; load wins over counting, wrap flags the last count.
module dpg_wrap_counter #(
  parameter int W = 32
) (
  input  logic         workClk,
  input  logic         sysRst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = (cnt == modulus - W'(1));

  always_ff @(posedge workClk or posedge sysRst) begin
    if (sysRst)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= wrap ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/dual_phase_generator.sv
// Two-channel square-wave generator with programmable period, high time and
// CHA->CHB offset; new configs are applied only at period boundaries.
module dual_phase_generator
  import dpg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             workClk,
  input  logic             sysRst,
  input  logic             enable,
  input  logic             cfgLoad,
  input  logic [CNT_W-1:0] periodCfg,
  input  logic [CNT_W-1:0] highCfg,
  input  logic [CNT_W-1:0] phaseCfg,
  output logic             CHA,
  output logic             CHB,
  output logic             periodStart,
  output logic             cfgErr,
  output logic             cfgPending
);
  state_t           state;
  cfg_t             act, shd, cfg_in, nxt_cfg;
  logic             valid, ld, wrap_a, wrap_b_unused;
  logic [CNT_W-1:0] cnt_a, cnt_b, ld_val_b;

  assign cfg_in = '{period: periodCfg, high: highCfg, phase: phaseCfg};
  assign valid  = cfgLoad && cfg_valid(cfg_in);

  // Config in force after an apply point: a same-edge load beats a pending shadow
  always_comb begin
    nxt_cfg = act;
    if (valid)           nxt_cfg = cfg_in;
    else if (cfgPending) nxt_cfg = shd;
  end

  // Counters free-run only mid-period in RUN; every other edge reloads them
  assign ld       = !(state == RUN && enable && !wrap_a);
  assign ld_val_b = enable ? phase_start(nxt_cfg) : '0;

  dpg_wrap_counter #(.W(CNT_W)) u_cnt_a (
    .workClk(workClk), .sysRst(sysRst), .load(ld), .load_val('0),
    .en(state == RUN), .modulus(act.period), .cnt(cnt_a), .wrap(wrap_a)
  );

  dpg_wrap_counter #(.W(CNT_W)) u_cnt_b (
    .workClk(workClk), .sysRst(sysRst), .load(ld), .load_val(ld_val_b),
    .en(state == RUN), .modulus(act.period), .cnt(cnt_b), .wrap(wrap_b_unused)
  );

  always_ff @(posedge workClk or posedge sysRst) begin
    if (sysRst) begin
      state       <= IDLE;
      act         <= CFG_RST;
      shd         <= '0;
      cfgPending  <= 1'b0;
      CHA         <= 1'b0;
      CHB         <= 1'b0;
      periodStart <= 1'b0;
      cfgErr      <= 1'b0;
    end else begin
      cfgErr      <= cfgLoad && !valid;
      CHA         <= (state == RUN) && (cnt_a < act.high);
      CHB         <= (state == RUN) && (cnt_b < act.high);
      periodStart <= (state == RUN) && (cnt_a == '0);
      if (state == IDLE) begin
        act <= nxt_cfg;
        if (enable) state <= RUN;
      end else if (!enable || wrap_a) begin
        act        <= nxt_cfg;
        cfgPending <= 1'b0;
        if (!enable) state <= IDLE;
      end else if (valid) begin
        shd        <= cfg_in;
        cfgPending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dual_phase_generator.sv
// Directed bench: waveforms checked cycle by cycle against a small P/H/D model.
module tb_dual_phase_generator;
  logic        workClk, sysRst, enable, cfgLoad;
  logic [31:0] periodCfg, highCfg, phaseCfg;
  logic        CHA, CHB, periodStart, cfgErr, cfgPending;
  int          checks = 0;
  int          failures = 0;
  string       step = "init";

  dual_phase_generator dut (
    .workClk(workClk), .sysRst(sysRst), .enable(enable), .cfgLoad(cfgLoad),
    .periodCfg(periodCfg), .highCfg(highCfg), .phaseCfg(phaseCfg),
    .CHA(CHA), .CHB(CHB), .periodStart(periodStart),
    .cfgErr(cfgErr), .cfgPending(cfgPending)
  );

  initial workClk = 1'b0;
  always #5 workClk = ~workClk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s: observed=%0d expected=%0d", step, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge workClk);
    #1;
    cfgLoad = 1'b0;
  endtask

  task automatic load(input int p, input int h, input int d);
    periodCfg = p; highCfg = h; phaseCfg = d; cfgLoad = 1'b1;
  endtask

  // n edges; outputs after the j-th edge reflect cntA = (a0+j) mod p
  task automatic run(input int p, input int h, input int d, input int a0, input int n);
    for (int j = 0; j < n; j++) begin
      int a, b;
      tick();
      a = (a0 + j) % p;
      b = (a + p - d) % p;
      chk($sformatf("CHA@a%0d", a), CHA, int'(a < h));
      chk($sformatf("CHB@a%0d", a), CHB, int'(b < h));
      chk($sformatf("pstart@a%0d", a), periodStart, int'(a == 0));
    end
  endtask

  initial begin
    int bp[4] = '{10, 10, 1, 10};
    int bh[4] = '{0, 10, 1, 5};
    int bd[4] = '{0, 0, 0, 10};
    sysRst = 1'b1; enable = 1'b0; cfgLoad = 1'b0;
    periodCfg = '0; highCfg = '0; phaseCfg = '0;
    tick(); tick();
    step = "reset";
    chk("CHA", CHA, 0); chk("CHB", CHB, 0); chk("pstart", periodStart, 0);
    chk("cfgErr", cfgErr, 0); chk("pending", cfgPending, 0);

    step = "default_cfg";
    sysRst = 1'b0; enable = 1'b1;
    tick(); chk("CHA_first", CHA, 0);
    run(2, 1, 0, 0, 5);
    step = "async_reset";
    sysRst = 1'b1; #1;
    chk("CHA", CHA, 0); chk("CHB", CHB, 0); chk("pstart", periodStart, 0); chk("cfgErr", cfgErr, 0);
    enable = 1'b0; tick(); sysRst = 1'b0; tick();

    step = "p10_h5_d3";
    load(10, 5, 3); enable = 1'b1;
    tick(); chk("CHA_first", CHA, 0); chk("pending", cfgPending, 0);
    run(10, 5, 3, 0, 25);

    step = "reload_d0";
    load(10, 5, 0);
    run(10, 5, 3, 5, 1); chk("pending", cfgPending, 1);
    run(10, 5, 3, 6, 3); chk("pending_hold", cfgPending, 1);
    run(10, 5, 3, 9, 1); chk("pending_clr", cfgPending, 0);
    run(10, 5, 0, 0, 12);
    step = "reload_d9";
    load(10, 5, 9);
    run(10, 5, 0, 2, 1); chk("pending", cfgPending, 1);
    run(10, 5, 0, 3, 7);
    run(10, 5, 9, 0, 20);

    step = "bad_cfg";
    for (int i = 0; i < 4; i++) begin
      load(bp[i], bh[i], bd[i]);
      run(10, 5, 9, 2 * i, 1);
      chk($sformatf("err%0d", i), cfgErr, 1); chk($sformatf("pend%0d", i), cfgPending, 0);
      run(10, 5, 9, 2 * i + 1, 1);
      chk($sformatf("err_clr%0d", i), cfgErr, 0);
    end
    step = "load_on_wrap";
    run(10, 5, 9, 8, 1);
    load(10, 5, 3);
    run(10, 5, 9, 9, 1); chk("pending", cfgPending, 0);
    run(10, 5, 3, 0, 10);

    step = "reload_p8";
    run(10, 5, 3, 0, 3);
    load(8, 2, 4);
    run(10, 5, 3, 3, 1); chk("pending", cfgPending, 1);
    run(10, 5, 3, 4, 5); chk("pending_hold", cfgPending, 1);
    run(10, 5, 3, 9, 1); chk("pending_clr", cfgPending, 0);
    run(8, 2, 4, 0, 16);

    step = "stop_restart";
    run(8, 2, 4, 0, 1);
    enable = 1'b0;
    run(8, 2, 4, 1, 1);
    tick(); chk("CHA_off", CHA, 0); chk("CHB_off", CHB, 0); chk("pstart_off", periodStart, 0);
    tick(); chk("CHA_idle", CHA, 0);
    enable = 1'b1;
    tick(); chk("CHA_first", CHA, 0);
    run(8, 2, 4, 0, 16);

    step = "stop_applies_shadow";
    load(6, 3, 1);
    run(8, 2, 4, 0, 1); chk("pending", cfgPending, 1);
    enable = 1'b0;
    run(8, 2, 4, 1, 1); chk("pending_clr", cfgPending, 0);
    tick(); chk("CHA_off", CHA, 0);
    enable = 1'b1;
    tick(); chk("CHA_first", CHA, 0);
    run(6, 3, 1, 0, 12);

    step = "reset_defaults";
    sysRst = 1'b1; #1;
    chk("CHA", CHA, 0); chk("pending", cfgPending, 0);
    sysRst = 1'b0;
    tick(); chk("CHA_first", CHA, 0);
    run(2, 1, 0, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
